// File: rtl/norm_pkg.sv
// Shared definitions for the psum normalizer: FSM state encoding and the
// fixed-point fraction width of the normalized lanes.
package norm_pkg;

    localparam int NORM_FRAC = 12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUM  = 3'd1,
        XCHG = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } norm_state_e;

endpackage

// File: rtl/norm_div.sv
// Serial restoring divider, one quotient bit per cycle. The start cycle
// already performs the first iteration, so a result takes exactly DVD_W cycles.
module norm_div #(
    parameter int DVD_W = 24,
    parameter int DVS_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVD_W-1:0] quotient_o
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d, rem_in;
    logic [DVD_W-1:0] quo_q, quo_d, quo_in;
    logic [DVS_W:0]   trial;
    logic             fits;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // Quotient bits shift in from the right as dividend bits shift out the left.
    always_comb begin
        rem_in = start_i ? '0 : rem_q;
        quo_in = start_i ? dividend_i : quo_q;
        trial  = {rem_in, quo_in[DVD_W-1]};
        fits   = (trial >= {1'b0, divisor_i});
        rem_d  = fits ? DVS_W'(trial - {1'b0, divisor_i}) : trial[DVS_W-1:0];
        quo_d  = {quo_in[DVD_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(DVD_W - 1);
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CNT_W'(1));
    assign quotient_o = quo_d;

endmodule

// File: rtl/norm_unit.sv
// Normalizes a vector of signed psums by the sum of their magnitudes (Q.12).
// Optional macro NORM_DUAL_CORE_SUM_EN adds the partner core's sum to the divisor.
module norm_unit
    import norm_pkg::*;
#(
    parameter int bw_psum = 12,
    parameter int col     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [bw_psum*col-1:0] psum_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [bw_psum+6:0]     sum_out,
    output logic                   sum_out_valid,
    input  logic [bw_psum+6:0]     sum_in,
    input  logic                   sum_in_valid,
    output logic [bw_psum*col-1:0] norm_out,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int SUM_W  = bw_psum + 7;
    localparam int DVD_W  = bw_psum + NORM_FRAC;
    localparam int LANE_W = (col > 1) ? $clog2(col) : 1;

    norm_state_e state_q, state_d;

    logic [bw_psum-1:0] psum_q [col];
    logic [bw_psum-1:0] abs_d  [col];
    logic [bw_psum-1:0] abs_q  [col];
    logic [bw_psum-1:0] norm_q [col];
    logic [SUM_W-1:0]   sum_d, sum_q, t_d, t_q;
    logic [LANE_W-1:0]  lane_q;
    logic               in_ready_d, in_ready_q;
    logic               accept, xchg_go, t_zero, last_lane;
    logic               div_start, div_busy, div_done;
    logic [DVD_W-1:0]   div_quo;
    logic               unused_quo_hi;

    assign accept    = in_valid && in_ready_q;
    assign t_zero    = (t_q == '0);
    assign last_lane = (lane_q == LANE_W'(col - 1));

`ifdef NORM_DUAL_CORE_SUM_EN
    assign xchg_go = sum_in_valid;
    assign t_d     = sum_q + sum_in;
`else
    logic unused_sum_in;
    assign unused_sum_in = ^{sum_in, sum_in_valid};
    assign xchg_go = 1'b1;
    assign t_d     = sum_q;
`endif

    // Unsigned magnitude: the most negative code maps onto 2^(bw_psum-1).
    always_comb begin
        sum_d = '0;
        for (int q = 0; q < col; q++) begin
            abs_d[q] = psum_q[q][bw_psum-1] ? -psum_q[q] : psum_q[q];
            sum_d    = sum_d + SUM_W'(abs_d[q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SUM;
            SUM:  state_d = XCHG;
            XCHG: if (xchg_go) state_d = DIV;
            DIV: begin
                if (t_zero || (div_done && last_lane)) begin
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d    = (state_d == IDLE);
        out_valid     = (state_q == DONE);
        sum_out_valid = (state_q == XCHG) || (state_q == DIV) || (state_q == DONE);
        div_start     = (state_q == DIV) && !t_zero && !div_busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b0;
            sum_q      <= '0;
            t_q        <= '0;
            lane_q     <= '0;
            for (int q = 0; q < col; q++) begin
                psum_q[q] <= '0;
                abs_q[q]  <= '0;
                norm_q[q] <= '0;
            end
        end else begin
            in_ready_q <= in_ready_d;
            if (accept) begin
                for (int q = 0; q < col; q++) begin
                    psum_q[q] <= psum_in[bw_psum*q +: bw_psum];
                end
            end
            if (state_q == SUM) begin
                abs_q <= abs_d;
                sum_q <= sum_d;
            end
            if ((state_q == XCHG) && xchg_go) begin
                t_q    <= t_d;
                lane_q <= '0;
            end
            if (state_q == DIV) begin
                if (t_zero) begin
                    for (int q = 0; q < col; q++) begin
                        norm_q[q] <= '0;
                    end
                end else if (div_done) begin
                    norm_q[lane_q] <= div_quo[bw_psum-1:0];
                    lane_q         <= lane_q + LANE_W'(1);
                end
            end
        end
    end

    norm_div #(
        .DVD_W (DVD_W),
        .DVS_W (SUM_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i ({abs_q[lane_q], {NORM_FRAC{1'b0}}}),
        .divisor_i  (t_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Quotients of 2^bw_psum and above wrap; only the low bits are kept.
    assign unused_quo_hi = ^div_quo[DVD_W-1:bw_psum];

    // Lane 0 sits in the most significant slot of the output bus.
    always_comb begin
        norm_out = '0;
        for (int q = 0; q < col; q++) begin
            norm_out[bw_psum*(col-1-q) +: bw_psum] = norm_q[q];
        end
    end

    assign in_ready = in_ready_q;
    assign sum_out  = sum_q;

endmodule

// File: tb/tb_norm_unit.sv
// Directed bench for norm_unit (bw_psum=12, col=8) with an arithmetic reference model.
// Build with NORM_DUAL_CORE_SUM_EN defined to exercise the partner-sum exchange.
module tb_norm_unit;
    localparam int BW  = 12;
    localparam int COL = 8;

    logic                clk;
    logic                reset;
    logic [BW*COL-1:0]   psum_in;
    logic                in_valid;
    logic                in_ready;
    logic [BW+6:0]       sum_out;
    logic                sum_out_valid;
    logic [BW+6:0]       sum_in;
    logic                sum_in_valid;
    logic [BW*COL-1:0]   norm_out;
    logic                out_valid;
    logic                out_ready;

    int checks;
    int failures;

    logic [BW+6:0]     exp_sum;
    logic [BW*COL-1:0] exp_norm;

    norm_unit #(.bw_psum(BW), .col(COL)) dut (
        .clk           (clk),
        .reset         (reset),
        .psum_in       (psum_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sum_out       (sum_out),
        .sum_out_valid (sum_out_valid),
        .sum_in        (sum_in),
        .sum_in_valid  (sum_in_valid),
        .norm_out      (norm_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: magnitudes, their sum, and truncated Q.12 ratios.
    function automatic void model(input logic [BW*COL-1:0] vec, input int sin_val,
                                  output logic [BW+6:0] e_sum, output logic [BW*COL-1:0] e_norm,
                                  output int div_len);
        int a [COL];
        int s;
        int t;
        int v;
        s = 0;
        for (int q = 0; q < COL; q++) begin
            v    = $signed(vec[q*BW +: BW]);
            a[q] = (v < 0) ? -v : v;
            s    = s + a[q];
        end
        t = s;
`ifdef NORM_DUAL_CORE_SUM_EN
        t = s + sin_val;
`else
        v = sin_val;
`endif
        t       = t % (1 << (BW + 7));
        e_sum   = (BW+7)'(s);
        e_norm  = '0;
        for (int q = 0; q < COL; q++) begin
            e_norm[BW*(COL-1-q) +: BW] = (t == 0) ? '0 : BW'(((a[q] * 4096) / t) % 4096);
        end
        div_len = (t == 0) ? 1 : COL * (BW + 12);
    endfunction

    // Continuous compare against the model whenever outputs are meaningful.
    always @(negedge clk) begin
        if (!reset) begin
            if (sum_out_valid) chk("sum_out", sum_out, exp_sum);
            if (out_valid) begin
                chk("norm_out", norm_out, exp_norm);
                chk("sov_in_done", sum_out_valid, 1'b1);
            end
            if (out_valid || sum_out_valid) chk("in_ready_busy", in_ready, 1'b0);
        end
    end

    task automatic run_vec(input string tag, input logic [BW*COL-1:0] vec,
                           input int sin_delay, input int sin_val, input int hold,
                           input bit use_lit, input logic [BW*COL-1:0] lit_norm,
                           input logic [BW+6:0] lit_sum);
        int n;
        int div_len;
        int exp_lat;
        int xchg_len;
        model(vec, sin_val, exp_sum, exp_norm, div_len);
`ifdef NORM_DUAL_CORE_SUM_EN
        xchg_len = sin_delay + 1;
`else
        xchg_len = 1;
`endif
        exp_lat = 1 + xchg_len + div_len + 1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        psum_in  = vec;
        in_valid = 1'b1;
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 1000) begin
            if (n == 2 + sin_delay) begin
                sum_in       = (BW+7)'(sin_val);
                sum_in_valid = 1'b1;
            end else if (n == 3 + sin_delay) begin
                sum_in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        sum_in_valid = 1'b0;
        chk({tag, "_latency"}, n, exp_lat);
        if (use_lit) begin
            chk({tag, "_lit_norm"}, norm_out, lit_norm);
            chk({tag, "_lit_sum"}, sum_out, lit_sum);
        end
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_inrdy"}, in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, out_valid, 1'b0);
        chk({tag, "_idle_inrdy"}, in_ready, 1'b1);
    endtask

    initial begin
        int lanes [COL];
        logic [BW*COL-1:0] v;
        logic [BW*COL-1:0] p5;
        int dl;
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        psum_in      = '0;
        in_valid     = 1'b0;
        sum_in       = '0;
        sum_in_valid = 1'b0;
        out_ready    = 1'b0;
        exp_sum      = '0;
        exp_norm     = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sov", sum_out_valid, 1'b0);
        chk("rst_sum_out", sum_out, '0);
        chk("rst_norm_out", norm_out, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        run_vec("zeros", '0, 0, 0, 0, 1'b1, '0, '0);

        v = {72'h0, 12'hF9C, 12'h064};
        run_vec("pm100", v, 0, 0, 5, 1'b1, 96'h800_800_000_000_000_000_000_000, 19'd200);

        run_vec("ones", {COL{12'h001}}, 0, 0, 1, 1'b1, {COL{12'h200}}, 19'd8);

`ifdef NORM_DUAL_CORE_SUM_EN
        p5 = {COL{12'h100}};
`else
        p5 = {COL{12'h200}};
`endif
        run_vec("fives", {COL{12'h005}}, 6, 40, 0, 1'b1, p5, 19'd40);

        v = {48'h0, 12'h800, 36'h0};
        run_vec("minneg", v, 0, 0, 0, 1'b1, '0, 19'd2048);

        lanes = '{7, -3, 0, 100, -2048, 2047, 1, -1};
        for (int q = 0; q < COL; q++) v[q*BW +: BW] = BW'(lanes[q]);
        run_vec("mixed", v, 2, 7, 2, 1'b0, '0, '0);

        for (int r = 0; r < 2; r++) begin
            v = {$urandom, $urandom, $urandom};
            run_vec("random", v, r, int'($urandom_range(0, 500)), r, 1'b0, '0, '0);
        end

        // Reset while dividing: vector abandoned, no output.
        v = {COL{12'h0F3}};
        model(v, 0, exp_sum, exp_norm, dl);
        dl = 0;
        while (!in_ready && dl < 50) begin
            @(negedge clk);
            dl++;
        end
        psum_in  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid     = 1'b0;
        sum_in       = '0;
        sum_in_valid = 1'b1;
        repeat (40) @(negedge clk);
        sum_in_valid = 1'b0;
        chk("middiv_sov", sum_out_valid, 1'b1);
        chk("middiv_out_valid", out_valid, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_sov", sum_out_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b0);
        chk("mrst_sum_out", sum_out, '0);
        chk("mrst_norm_out", norm_out, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_post_in_ready", in_ready, 1'b1);
        chk("mrst_post_out_valid", out_valid, 1'b0);
        chk("mrst_post_sov", sum_out_valid, 1'b0);

        v = {72'h0, 12'hF9C, 12'h064};
        run_vec("after_rst", v, 0, 0, 0, 1'b1, 96'h800_800_000_000_000_000_000_000, 19'd200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
